// File: rtl/unidade_busca.sv
// Instruction fetch unit: 5-bit PC, IF/ID register, branch/jump redirect with a
// one-cycle flush bubble, and a counter of delivered instructions.
module unidade_busca #(
  parameter logic [4:0] RESET_PC = 5'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  mem_addr,
  input  logic [31:0] mem_instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] if_instr,
  output logic [4:0]  if_pc,
  output logic        if_valid,
  output logic [7:0]  fetch_count,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [4:0] pc;
  logic [1:0] state;
  logic       redirect;
  logic [4:0] target;
  logic       hold;
  logic       unused_bits;

  assign mem_addr  = pc;
  assign fsm_state = state;

  // Handshake: if_valid is the producer's valid, and stall is the inverse of
  // the decode stage's ready. While stalled in RUN the IF/ID register holds;
  // a redirect from the instruction in if_instr still wins over stall.
  assign redirect = (state == RUN) && if_valid && (jump || branch_taken);
  assign hold     = (state == RUN) && stall && !redirect;

  // Only the low 5 bits matter: the memory holds 32 words and wraps.
  assign target = jump ? jump_target[4:0]
                       : (if_pc + 5'd1 + branch_offset[4:0]);

  assign unused_bits = ^{branch_offset[15:5], jump_target[25:5]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_instr    <= 32'h0;
      if_pc       <= 5'h0;
      if_valid    <= 1'b0;
      fetch_count <= 8'h0;
      state       <= BOOT;
    end else if (redirect) begin
      pc       <= target;
      if_instr <= 32'h0;
      if_valid <= 1'b0;
      state    <= FLUSH;
    end else if (!hold) begin
      if_instr    <= mem_instr;
      if_pc       <= pc;
      if_valid    <= 1'b1;
      pc          <= pc + 5'd1;
      fetch_count <= fetch_count + 8'd1;
      state       <= RUN;
    end
  end

endmodule
